param_dram: RTL and testbench

//  Parametrised single-port data RAM; next generation of the processor's data memory.

---
 rtl/dram_pkg.sv | 18 +
 rtl/dram_array.sv | 28 ++
 rtl/param_dram.sv | 167 ++++++++++++++++
 tb/tb_param_dram.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the parametrised data RAM: FSM state encoding and default geometry.
package dram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DEPTH  = 32;

    // Index width of the storage array; a single-word array still needs one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dram_array.sv
// Storage for param_dram: one write port and one registered read port, no reset.
module dram_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents; write-first is resolved by the caller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_dram.sv
// Parametrised single-port data RAM with reset clear sweep, write-first reads and range check.
// Define DRAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module param_dram
    import dram_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       DEPTH     = DEF_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam int unsigned AW    = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;

    logic               in_range;
    logic               accept;
    logic               rd_acc;
    logic               arr_we;
    logic [AW-1:0]      arr_waddr;
    logic [DATA_W-1:0]  arr_wdata;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;

    logic               vld1;
    logic               err1;
    logic               zero1;
    logic               fwd1;
    logic [DATA_W-1:0]  fwd_data1;
    logic [DATA_W-1:0]  data1_c;

    // Request gating and range check; DEPTH may equal 2**ADDR_W, so compare one bit wider.
    always_comb begin
        in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
        accept   = !busy_q && !rst && (write_en || read_en);
        rd_acc   = accept && read_en;
    end

    // The sweep owns the write port while clearing; no requests are accepted then.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = AW'(addr);
        arr_wdata = Data_in;
        if (state == S_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = AW'(cnt);
            arr_wdata = CLEAR_VAL;
        end else if (accept && write_en && in_range) begin
            arr_we = 1'b1;
        end
        arr_re = rd_acc && in_range;
    end

    dram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (AW'(addr)),
        .rdata (arr_rdata)
    );

    // Clear-sweep FSM: one word per cycle, busy drops after the last word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state  <= S_READY;
                        busy_q <= 1'b0;
                    end
                end
                S_READY: begin
                    state <= S_READY;
                end
                default: begin
                    state  <= S_CLEAR;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // First read stage: the select flags only update on an accepted read so Data_out holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1      <= 1'b0;
            err1      <= 1'b0;
            zero1     <= 1'b1;
            fwd1      <= 1'b0;
            fwd_data1 <= '0;
        end else begin
            vld1 <= rd_acc;
            err1 <= accept && !in_range;
            if (rd_acc) begin
                zero1     <= !in_range;
                fwd1      <= write_en;
                fwd_data1 <= Data_in;
            end
        end
    end

    always_comb begin
        data1_c = arr_rdata;
        if (zero1) begin
            data1_c = '0;
        end else if (fwd1) begin
            data1_c = fwd_data1;
        end
    end

`ifdef DRAM_OUTREG_EN
    logic [DATA_W-1:0] data2;
    logic              vld2;
    logic              err2;

    always_ff @(posedge clk) begin
        if (rst) begin
            data2 <= '0;
            vld2  <= 1'b0;
            err2  <= 1'b0;
        end else begin
            vld2 <= vld1;
            err2 <= err1;
            if (vld1) begin
                data2 <= data1_c;
            end
        end
    end

    assign Data_out = data2;
    assign rd_valid = vld2;
    assign addr_err = err2;
`else
    assign Data_out = data1_c;
    assign rd_valid = vld1;
    assign addr_err = err1;
`endif

    assign busy = busy_q;

endmodule

// File: tb/tb_param_dram.sv
// Self-checking bench for param_dram: DEPTH=32 and DEPTH=20 instances share stimulus,
// each checked every cycle against a behavioural memory model.
module tb_param_dram;

`ifdef DRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic        read_en;
    logic [8:0]  addr;
    logic [15:0] data_in;

    logic [15:0] dout [2];
    logic        vld  [2];
    logic        err  [2];
    logic        bsy  [2];

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem       [2][32];
    int          busy_left [2];
    res_t        pipe      [2][LAT];
    logic [15:0] exp_dout  [2];

    always #5 clk = ~clk;

    param_dram #(.DATA_W(16), .ADDR_W(9), .DEPTH(32), .CLEAR_VAL(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
        .Data_in(data_in), .Data_out(dout[0]), .rd_valid(vld[0]), .addr_err(err[0]),
        .busy(bsy[0])
    );

    param_dram #(.DATA_W(16), .ADDR_W(9), .DEPTH(20), .CLEAR_VAL(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
        .Data_in(data_in), .Data_out(dout[1]), .rd_valid(vld[1]), .addr_err(err[1]),
        .busy(bsy[1])
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 20;
    endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // One clock: drive at negedge, advance the model, check every output just after the edge.
    task automatic cycle(input logic r, input logic w, input logic rd,
                         input logic [8:0] a, input logic [15:0] d);
        res_t res;
        res_t expr;
        logic acc;
        logic inr;
        @(negedge clk);
        rst = r; write_en = w; read_en = rd; addr = a; data_in = d;
        for (int k = 0; k < 2; k++) begin
            res = '{v: 1'b0, e: 1'b0, d: 16'h0};
            if (r) begin
                busy_left[k] = depth_of(k);
                for (int i = 0; i < 32; i++) mem[k][i] = 16'h0;
                for (int s = 0; s < LAT; s++) pipe[k][s] = res;
                exp_dout[k] = 16'h0;
            end else begin
                acc = (busy_left[k] == 0) && (w || rd);
                if (busy_left[k] > 0) busy_left[k]--;
                inr = (int'(a) < depth_of(k));
                if (acc) begin
                    res.v = rd;
                    res.e = !inr;
                    res.d = !inr ? 16'h0 : (w ? d : mem[k][a]);
                    if (w && inr) mem[k][a] = d;
                end
                for (int s = LAT - 1; s > 0; s--) pipe[k][s] = pipe[k][s-1];
                pipe[k][0] = res;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            expr = pipe[k][LAT-1];
            if (r) expr = '{v: 1'b0, e: 1'b0, d: 16'h0};
            if (expr.v) exp_dout[k] = expr.d;
            chk("busy",     k, 16'(bsy[k]), 16'(busy_left[k] > 0));
            chk("rd_valid", k, 16'(vld[k]), 16'(expr.v));
            chk("addr_err", k, 16'(err[k]), 16'(expr.e));
            chk("Data_out", k, dout[k],     exp_dout[k]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 9'd0, 16'h0);
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = '0; data_in = '0;
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = depth_of(k);
            exp_dout[k]  = 16'h0;
        end

        // Reset held 3 cycles; write to word 5 while sweeping must be ignored.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 9'd5, 16'hBEEF);
        idle(31);
        cycle(1'b0, 1'b0, 1'b1, 9'd7, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 9'd5, 16'h0);
        idle(2);

        // Writes then back-to-back reads.
        cycle(1'b0, 1'b1, 1'b0, 9'd1, 16'd80);
        cycle(1'b0, 1'b1, 1'b0, 9'd2, 16'd50);
        cycle(1'b0, 1'b0, 1'b1, 9'd1, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 9'd2, 16'h0);
        idle(2);

        // Read-during-write forwards the new data.
        cycle(1'b0, 1'b1, 1'b1, 9'd3, 16'h1234);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 9'd3, 16'h0);
        idle(2);

        // Address 25: in range for DEPTH=32, out of range for DEPTH=20.
        cycle(1'b0, 1'b1, 1'b0, 9'd25, 16'h00FF);
        cycle(1'b0, 1'b0, 1'b1, 9'd25, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 9'd511, 16'h0);
        idle(2);

        // Reset interrupting the sweep restarts it; earlier data is cleared.
        cycle(1'b0, 1'b1, 1'b0, 9'd9, 16'hAAAA);
        cycle(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
        idle(10);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
        idle(32);
        cycle(1'b0, 1'b0, 1'b1, 9'd9, 16'h0);
        idle(2);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom),
                  9'($urandom_range(0, 40)), 16'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
